// File: rtl/qpsk_pkg.sv
// Shared constants and types for the QPSK dibit datapath (transmit splitter and receive packer).
// Purely declarative; no timing of its own.
// Holds word/dibit geometry, DAC amplitude constants and the output-slot state encoding.
package qpsk_pkg;

    localparam int WORD_W        = 32;
    localparam int DIBIT_W       = 2;
    localparam int SYMS_PER_WORD = 16;

    // DAC amplitude codes used by the transmit side for a '1' and a '0' bit.
    localparam logic [15:0] ONE  = 16'h6665;
    localparam logic [15:0] ZERO = 16'h999B;

    // Symbol index of the last dibit in a word.
    localparam logic [3:0] LAST_SYM = 4'(SYMS_PER_WORD - 1);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/qpsk_axis_slot.sv
// One-entry AXI-Stream output register: load, drain, hold; a load may coincide with a drain.
// Latency: one cycle from load to out_tvalid.
// Backpressure: can_load is high when empty or when the held word drains this cycle.
// Ports: clk/reset (async, active-high); load/load_tdata/load_tlast write side;
//        can_load tells the producer a load will be taken; out_* is the AXI-Stream master.
module qpsk_axis_slot
    import qpsk_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_tdata,
    input  logic              load_tlast,
    output logic              can_load,
    output logic [WORD_W-1:0] out_tdata,
    output logic              out_tvalid,
    output logic              out_tlast,
    input  logic              out_tready
);

    slot_state_e       state_q, state_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            // A load while draining simply replaces the departing word.
            state_d = SLOT_FULL;
            data_d  = load_tdata;
            last_d  = load_tlast;
        end else if (state_q == SLOT_FULL && out_tready) begin
            state_d = SLOT_EMPTY;
            last_d  = 1'b0;
        end
    end

    assign can_load   = (state_q == SLOT_EMPTY) || out_tready;
    assign out_tdata  = data_q;
    assign out_tvalid = (state_q == SLOT_FULL);
    assign out_tlast  = last_q;

endmodule

// File: rtl/qpsk_dibit_packer.sv
// Packs 16 consecutive 2-bit QPSK decisions from an AXI-Stream input into one 32-bit output word.
// Latency: out_tvalid one cycle after the 16th (or tlast) dibit is accepted; one dibit per clock.
// Backpressure: only the word-completing dibit is blocked while the output is full and stalled.
// Ports: clk, reset (async, active-high); in_tdata[1:0] dibit ([31:2] ignored), in_tvalid/in_tready;
//        out_tdata/out_tvalid/out_tready. Macro QPSK_PACKER_TLAST_EN adds in_tlast/out_tlast
//        for early packet-end flush with zero-filled unused positions.
// MSB_FIRST=1 puts the first dibit in [31:30]; MSB_FIRST=0 puts it in [1:0].
module qpsk_dibit_packer
    import qpsk_pkg::*;
#(
    parameter int MSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_tdata,
    input  logic        in_tvalid,
    output logic        in_tready,
`ifdef QPSK_PACKER_TLAST_EN
    input  logic        in_tlast,
    output logic        out_tlast,
`endif
    output logic [31:0] out_tdata,
    output logic        out_tvalid,
    input  logic        out_tready
);

    logic [3:0]         sym_cnt_q, sym_cnt_d;
    logic [29:0]        acc_q, acc_d;
    logic [DIBIT_W-1:0] dibit;
    logic               tlast_in;
    logic               end_of_word;
    logic               can_load;
    logic               acc_in;
    logic               load;
    logic [4:0]         shamt;
    logic [WORD_W-1:0]  merged;
    logic [29:0]        acc_next;
    logic               slot_last;
    logic               unused_in_hi;

    assign dibit        = in_tdata[1:0];
    assign unused_in_hi = ^in_tdata[31:2];

`ifdef QPSK_PACKER_TLAST_EN
    assign tlast_in  = in_tlast;
    assign out_tlast = slot_last;
`else
    assign tlast_in  = 1'b0;
    logic unused_slot_last;
    assign unused_slot_last = slot_last;
`endif

    // A dibit that completes a word needs room in the output slot; all others never stall.
    assign end_of_word = (sym_cnt_q == LAST_SYM) || tlast_in;
    assign in_tready   = !end_of_word || can_load;
    assign acc_in      = in_tvalid && in_tready;
    assign load        = acc_in && end_of_word;

    // Merge the incoming dibit into the partial word at its final bit position. The
    // accumulator stores the 30 bits that dibits 0..14 can occupy, so the full word is
    // the accumulator padded on the side where dibit 15 lands.
    always_comb begin
        shamt    = '0;
        merged   = '0;
        acc_next = '0;
        if (MSB_FIRST != 0) begin
            shamt    = 5'd30 - {sym_cnt_q, 1'b0};
            merged   = {acc_q, 2'b00} | (WORD_W'(dibit) << shamt);
            acc_next = merged[31:2];
        end else begin
            shamt    = {sym_cnt_q, 1'b0};
            merged   = {2'b00, acc_q} | (WORD_W'(dibit) << shamt);
            acc_next = merged[29:0];
        end
    end

    always_comb begin
        sym_cnt_d = sym_cnt_q;
        acc_d     = acc_q;
        if (acc_in) begin
            if (end_of_word) begin
                sym_cnt_d = '0;
                acc_d     = '0;
            end else begin
                sym_cnt_d = sym_cnt_q + 4'd1;
                acc_d     = acc_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_cnt_q <= '0;
            acc_q     <= '0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            acc_q     <= acc_d;
        end
    end

    qpsk_axis_slot u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_tdata (merged),
        .load_tlast (tlast_in),
        .can_load   (can_load),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tlast  (slot_last),
        .out_tready (out_tready)
    );

endmodule

// File: tb/tb_qpsk_dibit_packer.sv
module tb_qpsk_dibit_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_tdata = '0;
    logic        in_tvalid = 1'b0;
    logic        in_tlast = 1'b0;
    logic        out_tready = 1'b1;
    logic        in_tready, in_tready1;
    logic [31:0] out_tdata, out_tdata1;
    logic        out_tvalid, out_tvalid1;
    logic        out_tlast, out_tlast1;
    logic        in_tvalid1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Second instance (LSB-first) sees exactly the dibits the first one accepts.
    assign in_tvalid1 = in_tvalid && in_tready;

    qpsk_dibit_packer #(.MSB_FIRST(1)) dut0 (
        .clk(clk), .reset(reset), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
`ifdef QPSK_PACKER_TLAST_EN
        .in_tlast(in_tlast), .out_tlast(out_tlast),
`endif
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready)
    );

    qpsk_dibit_packer #(.MSB_FIRST(0)) dut1 (
        .clk(clk), .reset(reset), .in_tdata(in_tdata), .in_tvalid(in_tvalid1), .in_tready(in_tready1),
`ifdef QPSK_PACKER_TLAST_EN
        .in_tlast(in_tlast), .out_tlast(out_tlast1),
`endif
        .out_tdata(out_tdata1), .out_tvalid(out_tvalid1), .out_tready(1'b1)
    );

`ifndef QPSK_PACKER_TLAST_EN
    assign out_tlast  = 1'b0;
    assign out_tlast1 = 1'b0;
`endif

`ifdef QPSK_PACKER_TLAST_EN
    localparam bit TLAST_ON = 1'b1;
`else
    localparam bit TLAST_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference packing: dibit k of a word goes to bit pair (15-k) when MSB-first, k otherwise.
    function automatic logic [31:0] pack(input logic [1:0] d[$], input bit msb);
        logic [31:0] w = '0;
        for (int k = 0; k < d.size(); k++) begin
            if (msb) w = w | (32'(d[k]) << (2 * (15 - k)));
            else     w = w | (32'(d[k]) << (2 * k));
        end
        return w;
    endfunction

    logic [1:0]  pend[$];
    word_t       exp0[$], exp1[$];
    int          xfer_cyc[$];
    logic [31:0] last0 = '0, last1 = '0;
    logic        last0_tl = 1'b0;
    int          wc0 = 0;
    bit          watch_rdy = 1'b0;
    int          rdy_low = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    // Scoreboard: all sampling on the falling edge, inputs change just after the rising edge.
    always @(negedge clk) begin
        if (reset) begin
            pend.delete();
            exp0.delete();
            exp1.delete();
            prev_stall <= 1'b0;
        end else begin
            word_t w;
            bit    tl_eff;
            tl_eff = TLAST_ON && in_tlast;
            chk("out_tvalid_vs_model", {31'b0, out_tvalid}, {31'b0, exp0.size() != 0});
            chk("out_tvalid1_vs_model", {31'b0, out_tvalid1}, {31'b0, exp1.size() != 0});
            chk("in_tready_rule", {31'b0, in_tready},
                {31'b0, ((pend.size() != 15) && !tl_eff) || !out_tvalid || out_tready});
            if (prev_stall) chk("hold_stable", out_tdata, prev_data);
            if (watch_rdy && !in_tready) rdy_low++;
            if (out_tvalid && out_tready && exp0.size() != 0) begin
                w = exp0.pop_front();
                chk("word_msb", out_tdata, w.data);
                chk("tlast_msb", {31'b0, out_tlast}, {31'b0, w.last});
                last0 = out_tdata;
                last0_tl = out_tlast;
                wc0++;
                xfer_cyc.push_back(cyc);
            end
            if (out_tvalid1 && exp1.size() != 0) begin
                w = exp1.pop_front();
                chk("word_lsb", out_tdata1, w.data);
                chk("tlast_lsb", {31'b0, out_tlast1}, {31'b0, w.last});
                last1 = out_tdata1;
            end
            if (in_tvalid && in_tready) begin
                pend.push_back(in_tdata[1:0]);
                if (pend.size() == 16 || tl_eff) begin
                    exp0.push_back('{pack(pend, 1'b1), tl_eff});
                    exp1.push_back('{pack(pend, 1'b0), tl_eff});
                    pend.delete();
                end
            end
            prev_stall <= out_tvalid && !out_tready;
            prev_data  <= out_tdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        int t;
        t = 0;
        in_tdata  = d;
        in_tlast  = last;
        in_tvalid = 1'b1;
        @(negedge clk);
        while (!in_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("push_timeout", 32'(t), 32'd0);
        step();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [1:0] q[$];

        // Pin the reference packer to hand-computed values.
        q = {};
        for (int r = 0; r < 4; r++) q = {q, 2'd3, 2'd2, 2'd1, 2'd0};
        chk("model_e4", pack(q, 1'b1), 32'hE4E4E4E4);
        chk("model_1b", pack(q, 1'b0), 32'h1B1B1B1B);
        q = {2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        chk("model_ffc", pack(q, 1'b1), 32'hFFC00000);

        // Reset state.
        #2;
        chk("rst_tvalid", {31'b0, out_tvalid}, 32'd0);
        chk("rst_tdata", out_tdata, 32'd0);
        chk("rst_tlast", {31'b0, out_tlast}, 32'd0);
        chk("rst_tready", {31'b0, in_tready}, 32'd1);
        idle(2);
        reset = 1'b0;
        idle(1);

        // 3,2,1,0 x4.
        for (int r = 0; r < 4; r++)
            for (int k = 3; k >= 0; k--) push(32'(k), 1'b0);
        idle(2);
        chk("pattern_msb", last0, 32'hE4E4E4E4);
        chk("pattern_lsb", last1, 32'h1B1B1B1B);

        // Continuous stream of 64 ones.
        xfer_cyc.delete();
        wc0 = 0;
        watch_rdy = 1'b1;
        for (int i = 0; i < 64; i++) push(32'd1, 1'b0);
        idle(2);
        watch_rdy = 1'b0;
        chk("stream_words", 32'(wc0), 32'd4);
        chk("stream_ready_low", 32'(rdy_low), 32'd0);
        chk("stream_last", last0, 32'h55555555);
        for (int i = 1; i < xfer_cyc.size(); i++)
            chk("stream_spacing", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'd16);

        // Backpressure: first word held, next 15 accepted, 16th blocked.
        for (int i = 0; i < 16; i++) push(32'd2, 1'b0);
        out_tready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            in_tdata = 32'd1;
            in_tvalid = 1'b1;
            @(negedge clk);
            chk("bp_accept", {31'b0, in_tready}, 32'd1);
            step();
        end
        in_tdata = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_blocked", {31'b0, in_tready}, 32'd0);
            chk("bp_hold", out_tdata, 32'hAAAAAAAA);
            step();
        end
        out_tready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'b0, in_tready}, 32'd1);
        step();
        in_tvalid = 1'b0;
        @(negedge clk);
        chk("bp_new_valid", {31'b0, out_tvalid}, 32'd1);
        chk("bp_new_word", out_tdata, 32'h55555557);
        idle(2);

        // Reset mid-word discards the partial word.
        for (int i = 0; i < 7; i++) push(32'd2, 1'b0);
        reset = 1'b1;
        #2;
        chk("midrst_tvalid", {31'b0, out_tvalid}, 32'd0);
        chk("midrst_tready", {31'b0, in_tready}, 32'd1);
        idle(2);
        reset = 1'b0;
        wc0 = 0;
        idle(1);
        for (int i = 0; i < 16; i++) push(32'd1, 1'b0);
        idle(2);
        chk("midrst_words", 32'(wc0), 32'd1);
        chk("midrst_word", last0, 32'h55555555);

        // Upper input bits ignored.
        for (int i = 0; i < 16; i++) push(32'hFFFFFFFC, 1'b0);
        idle(2);
        chk("upper_ignored", last0, 32'h00000000);

        if (TLAST_ON) begin
            for (int i = 0; i < 5; i++) push(32'd3, i == 4);
            idle(2);
            chk("tlast_word", last0, 32'hFFC00000);
            chk("tlast_flag", {31'b0, last0_tl}, 32'd1);
            for (int i = 0; i < 16; i++) push(32'd1, 1'b0);
            idle(2);
            chk("after_tlast_word", last0, 32'h55555555);
            chk("after_tlast_flag", {31'b0, last0_tl}, 32'd0);
        end

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            in_tvalid  = ($urandom_range(0, 3) != 0);
            in_tdata   = $urandom();
            in_tlast   = TLAST_ON && ($urandom_range(0, 7) == 0);
            out_tready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_tvalid  = 1'b0;
        in_tlast   = 1'b0;
        out_tready = 1'b1;
        idle(4);
        chk("drain_empty", 32'(exp0.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qpsk_dibit_packer.md
Name: qpsk_dibit_packer

Overview:
Receive-side counterpart of the transmit dibit splitter. It collects 16 consecutive 2-bit QPSK symbol decisions from an AXI-Stream input and packs them into one 32-bit word on an AXI-Stream output. It sits between the demodulator hard-decision stage and the RFNoC output port. It sustains one dibit per clock with no bubbles at word boundaries.

Parameters:
MSB_FIRST, 1, 1: first dibit received lands in out_tdata[31:30] (its bit1 in [31]). 0: first dibit lands in [1:0].
SYMS_PER_WORD, 16, dibits per output word; fixed to 16 by the 32-bit output width. Not user-overridable.

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
in_tdata  in  32  [1:0] is the dibit; [31:2] is ignored
in_tvalid  in  1  input valid
in_tready  out  1  input ready
out_tdata  out  32  packed word
out_tvalid  out  1  output valid
out_tready  in  1  output ready
in_tlast  in  1  (QPSK_PACKER_TLAST_EN only) last dibit of packet
out_tlast  out  1  (QPSK_PACKER_TLAST_EN only) last word of packet

Behaviour:
- Input accept: acc_in = in_tvalid && in_tready. Output transfer: xfer_out = out_tvalid && out_tready.
- Symbol counter sym_cnt [3:0], range 0..15. It increments on each acc_in and wraps 15 -> 0 on the 16th accept.
- Accumulator acc[29:0] holds dibits 0..14 of the current word. Insertion position is selected by sym_cnt and MSB_FIRST.
- On acc_in with sym_cnt==15:
  - out_tdata <= acc merged with the current dibit.
  - out_tvalid <= 1 on the next edge. Latency is one cycle from the 16th accept to out_tvalid.
  - acc is cleared.
- Output slot states: EMPTY (out_tvalid=0) and FULL (out_tvalid=1).
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on xfer_out without a simultaneous load.
  - FULL -> FULL when xfer_out and a load occur in the same cycle. The new word replaces the old one.
- in_tready (combinational) = (sym_cnt != 15) || !out_tvalid || out_tready.
  - While FULL and stalled, dibits 0..14 of the next word are still accepted. Only the 16th is blocked.
  - in_tready never depends on in_tvalid.
- out_tdata is held stable while out_tvalid && !out_tready. It changes only on a load.
- Reset values: sym_cnt=0, acc=0, out_tdata=0, out_tvalid=0, out_tlast=0, in_tready=1.
- Reset mid-word discards the partial word and any held output word. There is no residue afterwards.
- Continuous in_tvalid=1 with out_tready=1 produces exactly one word per 16 cycles indefinitely.

Optional Feature:
Macro QPSK_PACKER_TLAST_EN.
- Defined:
  - in_tlast and out_tlast ports exist.
  - acc_in with in_tlast=1 at any sym_cnt loads the word immediately. Unfilled dibit positions are zero.
  - out_tlast=1 with that word; sym_cnt and acc reset to 0.
  - in_tready for a tlast dibit follows the same rule as sym_cnt==15: it is blocked while FULL and not draining.
- Undefined: no tlast ports; words are emitted only at 16-dibit boundaries.

Decomposition:
- Package qpsk_pkg holds:
  - localparams WORD_W=32, DIBIT_W=2, SYMS_PER_WORD=16;
  - DAC amplitude constants ONE=16'h6665 and ZERO=16'h999B, shared with the transmit side;
  - slot-state encodings.
- Natural sub-module: qpsk_axis_slot, a one-entry AXI-Stream output register (load/drain/hold, ready-through).

Test Plan:
- Feed dibits 3,2,1,0 repeated ×4 with out_tready=1 -> out_tdata=0xE4E4E4E4 (MSB_FIRST=1); 0x1B1B1B1B with MSB_FIRST=0.
- Continuous valid and ready over 64 dibits of 1 -> four words of 0x55555555, spaced exactly 16 cycles apart; in_tready constantly 1.
- Backpressure: after the first word, hold out_tready=0 -> next 15 dibits accepted, 16th sees in_tready=0 and out_tdata holds. Raise out_tready -> the 16th is accepted that cycle and the new word appears the next cycle.
- Reset after 7 dibits of 2, then 16 dibits of 1 -> a single word 0x55555555; no word containing 0xA pattern is emitted.
- in_tdata=0xFFFFFFFC ×16 -> out_tdata=0x00000000, proving [31:2] is ignored.
- TLAST_EN: 5 dibits of 3 with in_tlast on the 5th -> out_tdata=0xFFC00000 with out_tlast=1; the next word starts at sym_cnt=0.
